score_display: RTL and testbench
================================

SCORE_DISPLAY -- requirements
Module: score_display

Interface
REQ-001 clk  input  1  system clock, 12 MHz; the only clock.
REQ-002 nRst_i  input  1  reset, asynchronous, active-low.
REQ-003 score_i  input  7  binary score from the score counter; nominal range 0-99.
REQ-004 game_over_i  input  1  level; high while the game is over.
REQ-005 tens_seg_o  output  7  tens-digit segments {g,f,e,d,c,b,a}, active-high.
REQ-006 ones_seg_o  output  7  ones-digit segments {g,f,e,d,c,b,a}, active-high.
REQ-007 hi_tens_o, hi_ones_o  output  4 each  high-score BCD digits.
REQ-008 busy_o  output  1  high while a conversion is in progress.
REQ-009 valid_o  output  1  one-cycle pulse when new digits are committed.

Function
REQ-010 FSM states: IDLE, CONV, COMMIT; state register is the only control state.
REQ-011 IDLE: the block samples score_i at every edge and compares it against last_score (the binary value last committed).
REQ-012 IDLE, when score_i != last_score at edge N:
  - capture min(score_i, 99) into the shift register;
  - clear the BCD accumulator and iteration counter;
  - go to CONV.
REQ-013 Clamp rule: score_i values 100-127 convert as 99; last_score stores the raw score_i so that no retrigger loop occurs.
REQ-014 CONV performs a double-dabble step per edge at edges N+1..N+7 (7 iterations):
  - add 3 to any BCD nibble >= 5;
  - then shift left by one, taking the score MSB into the accumulator;
  - at the 7th step go to COMMIT.
REQ-015 COMMIT, edge N+8:
  - load tens/ones BCD registers and last_score;
  - assert valid_o for the following cycle only;
  - return to IDLE.
REQ-016 busy_o is high in CONV and COMMIT, and low in IDLE.
REQ-017 score_i changes during CONV or COMMIT are ignored in flight; they are detected in IDLE on the next edge after return (REQ-012). The newest value wins and no intermediate value is queued.
REQ-018 Segment encoding, hex, digits 0-9: 3F 06 5B 4F 66 6D 7D 07 7F 6F.
REQ-019 Segment decode is combinational from the committed BCD registers; the segment outputs never show accumulator contents mid-conversion.
REQ-020 Leading-zero blanking:
  - tens_seg_o is 7'h00 when the tens digit is 0;
  - the ones digit is always shown.
REQ-021 game_over_i is registered, and its rising edge is detected internally (edge detected at edge M).
REQ-022 On a detected rising edge, if the committed score > hi_score, then hi_score and hi BCD digits are loaded from the committed values at edge M+1.
REQ-023 If the detected rising edge coincides with COMMIT, the comparison uses the pre-commit value.
REQ-024 hi_score is never decreased except by reset.

Reset
REQ-025 nRst_i low sets, asynchronously:
  - state IDLE;
  - last_score, BCD registers, hi_score, hi digits and shift/accumulator all 0;
  - busy_o 0 and valid_o 0;
  - ones_seg_o 7'h3F and tens_seg_o 7'h00.
REQ-026 Reset mid-conversion aborts the conversion with no commit and no valid_o pulse; after release, normal detection per REQ-012 resumes.

Structure
REQ-027 Package score_display_pkg holds:
  - the state enum (IDLE, CONV, COMMIT);
  - MAX_SCORE = 99 and CONV_STEPS = 7;
  - the ten segment constants and SEG_BLANK = 7'h00.
REQ-028 One sub-module, seg7_decode (4-bit BCD in, 7-bit segments out, combinational), instantiated twice.

Verification
REQ-029 Reset release with score_i = 0 -> ones_seg_o = 3F, tens_seg_o = 00, busy_o = 0, and no valid_o for 20 cycles.
REQ-030 score_i 0->37 at edge N:
  - busy_o = 1 from edge N;
  - at edge N+8, tens_seg_o = 4F and ones_seg_o = 07;
  - valid_o high for exactly one cycle after edge N+8.
REQ-031 score_i = 99 -> segments 6F/6F; then score_i = 115 -> segments remain 6F/6F, one valid_o pulse, and no further conversions while 115 is held.
REQ-032 score_i 5->6 at edge N+3 of the conversion of 5:
  - 5 commits at N+8 (blank/6D);
  - 6 is detected at N+9 and commits at N+17 (blank/7D);
  - two valid_o pulses total.
REQ-033 Game over at committed 42 -> hi digits 4/2. Next game at committed 10 -> hi digits stay 4/2. Next game at committed 57 -> hi digits 5/7.
REQ-034 nRst_i pulsed low at edge N+4 of a conversion -> all outputs at reset values immediately, and no valid_o pulse.

Source files
------------

// File: rtl/score_display_pkg.sv
// Shared types, constants and helpers for the score display block.
package score_display_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CONV   = 2'd1,
      ST_COMMIT = 2'd2
   } state_t;

   localparam logic [6:0] MAX_SCORE  = 7'd99;
   localparam logic [2:0] CONV_STEPS = 3'd7;

   // Segment patterns, bit order {g,f,e,d,c,b,a}, active-high.
   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   // Scores above the two-digit range display as 99.
   function automatic logic [6:0] clamp_score(input logic [6:0] s);
      return (s > MAX_SCORE) ? MAX_SCORE : s;
   endfunction

   // One double-dabble iteration on {tens, ones, binary}: adjust, then shift.
   function automatic logic [14:0] dabble_step(input logic [14:0] v);
      logic [3:0]  t;
      logic [3:0]  o;
      logic [14:0] a;
      t = v[14:11];
      o = v[10:7];
      if (t >= 4'd5) t = t + 4'd3;
      if (o >= 4'd5) o = o + 4'd3;
      a = {t, o, v[6:0]};
      return {a[13:0], 1'b0};
   endfunction

endpackage

// File: rtl/score_display_seg7_decode.sv
// BCD digit to 7-segment pattern; optional blanking of a zero digit.
module seg7_decode
   import score_display_pkg::*;
(
   input  logic [3:0] bcd,
   input  logic       blank_zero,
   output logic [6:0] seg
);

   // Pure lookup; codes above 9 never occur on committed digits and show blank.
   always_comb begin
      seg = SEG_BLANK;
      case (bcd)
         4'd0:    seg = blank_zero ? SEG_BLANK : SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/score_display.sv
// Score to two-digit 7-segment display with high-score tracking.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  ST_IDLE   | watch score_i against last committed raw score
//  ST_CONV   | one double-dabble step per clock, 7 steps total
//  ST_COMMIT | latch BCD digits and raw score, pulse valid_o
module score_display
   import score_display_pkg::*;
(
   input  logic       clk,
   input  logic       nRst_i,
   input  logic [6:0] score_i,
   input  logic       game_over_i,
   output logic [6:0] tens_seg_o,
   output logic [6:0] ones_seg_o,
   output logic [3:0] hi_tens_o,
   output logic [3:0] hi_ones_o,
   output logic       busy_o,
   output logic       valid_o
);

   state_t      state;
   logic [6:0]  last_score;
   logic [6:0]  pending_score;
   logic [14:0] dd_reg;
   logic [2:0]  step_cnt;
   logic [3:0]  tens_bcd;
   logic [3:0]  ones_bcd;

   logic        go_q;
   logic        go_rise;
   logic [6:0]  hi_score;
   logic [6:0]  committed_score;

   // Conversion sequencer; the raw score is kept so a clamped value does not retrigger.
   always_ff @(posedge clk or negedge nRst_i) begin
      if (!nRst_i) begin
         state         <= ST_IDLE;
         last_score    <= '0;
         pending_score <= '0;
         dd_reg        <= '0;
         step_cnt      <= '0;
         tens_bcd      <= '0;
         ones_bcd      <= '0;
         busy_o        <= 1'b0;
         valid_o       <= 1'b0;
      end else begin
         valid_o <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (score_i != last_score) begin
                  pending_score <= score_i;
                  dd_reg        <= {8'h00, clamp_score(score_i)};
                  step_cnt      <= CONV_STEPS - 3'd1;
                  busy_o        <= 1'b1;
                  state         <= ST_CONV;
               end
            end
            ST_CONV: begin
               dd_reg <= dabble_step(dd_reg);
               if (step_cnt == 3'd0) begin
                  state <= ST_COMMIT;
               end else begin
                  step_cnt <= step_cnt - 3'd1;
               end
            end
            ST_COMMIT: begin
               tens_bcd   <= dd_reg[14:11];
               ones_bcd   <= dd_reg[10:7];
               last_score <= pending_score;
               valid_o    <= 1'b1;
               busy_o     <= 1'b0;
               state      <= ST_IDLE;
            end
            default: begin
               busy_o <= 1'b0;
               state  <= ST_IDLE;
            end
         endcase
      end
   end

   assign committed_score = clamp_score(last_score);

   // Game-over edge detect; the high score only ever rises, using values committed before this edge.
   always_ff @(posedge clk or negedge nRst_i) begin
      if (!nRst_i) begin
         go_q      <= 1'b0;
         go_rise   <= 1'b0;
         hi_score  <= '0;
         hi_tens_o <= '0;
         hi_ones_o <= '0;
      end else begin
         go_q    <= game_over_i;
         go_rise <= game_over_i & ~go_q;
         if (go_rise && (committed_score > hi_score)) begin
            hi_score  <= committed_score;
            hi_tens_o <= tens_bcd;
            hi_ones_o <= ones_bcd;
         end
      end
   end

   seg7_decode u_tens_dec (
      .bcd        (tens_bcd),
      .blank_zero (1'b1),
      .seg        (tens_seg_o)
   );

   seg7_decode u_ones_dec (
      .bcd        (ones_bcd),
      .blank_zero (1'b0),
      .seg        (ones_seg_o)
   );

endmodule

// File: tb/tb_score_display.sv
`timescale 1ns/1ps
module tb_score_display;

   logic       clk;
   logic       nRst_i;
   logic [6:0] score_i;
   logic       game_over_i;
   logic [6:0] tens_seg_o;
   logic [6:0] ones_seg_o;
   logic [3:0] hi_tens_o;
   logic [3:0] hi_ones_o;
   logic       busy_o;
   logic       valid_o;

   int checks = 0;
   int errors = 0;
   int valid_cnt = 0;

   score_display dut (
      .clk         (clk),
      .nRst_i      (nRst_i),
      .score_i     (score_i),
      .game_over_i (game_over_i),
      .tens_seg_o  (tens_seg_o),
      .ones_seg_o  (ones_seg_o),
      .hi_tens_o   (hi_tens_o),
      .hi_ones_o   (hi_ones_o),
      .busy_o      (busy_o),
      .valid_o     (valid_o)
   );

   initial clk = 1'b0;
   always #42 clk = ~clk;

   always @(negedge clk) if (valid_o === 1'b1) valid_cnt++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_score(input logic [6:0] s);
      score_i = s;
      repeat (11) tick();
   endtask

   task automatic test_reset();
      int c0;
      int bad;
      nRst_i = 1'b0;
      score_i = 7'd0;
      game_over_i = 1'b0;
      repeat (3) tick();
      checks++; if (ones_seg_o !== 7'h3F) begin errors++; $display("FAIL reset_ones: got %h expected 3f", ones_seg_o); end
      checks++; if (tens_seg_o !== 7'h00) begin errors++; $display("FAIL reset_tens: got %h expected 00", tens_seg_o); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
      checks++; if ({hi_tens_o, hi_ones_o} !== 8'h00) begin errors++; $display("FAIL reset_hi: got %h expected 00", {hi_tens_o, hi_ones_o}); end
      nRst_i = 1'b1;
      c0 = valid_cnt;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (busy_o !== 1'b0) bad++;
      end
      checks++; if (valid_cnt != c0) begin errors++; $display("FAIL idle_valid: got %0d pulses expected 0", valid_cnt - c0); end
      checks++; if (bad != 0) begin errors++; $display("FAIL idle_busy: got %0d busy cycles expected 0", bad); end
      checks++; if (ones_seg_o !== 7'h3F) begin errors++; $display("FAIL idle_ones: got %h expected 3f", ones_seg_o); end
   endtask

   task automatic test_convert_37();
      int c0;
      c0 = valid_cnt;
      score_i = 7'd37;
      tick();
      checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL c37_busy_n: got %b expected 1", busy_o); end
      repeat (7) tick();
      checks++; if ({tens_seg_o, ones_seg_o} !== {7'h00, 7'h3F}) begin errors++; $display("FAIL c37_hold_n7: got %h/%h expected 00/3f", tens_seg_o, ones_seg_o); end
      checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL c37_busy_n7: got %b expected 1", busy_o); end
      tick();
      checks++; if (tens_seg_o !== 7'h4F) begin errors++; $display("FAIL c37_tens: got %h expected 4f", tens_seg_o); end
      checks++; if (ones_seg_o !== 7'h07) begin errors++; $display("FAIL c37_ones: got %h expected 07", ones_seg_o); end
      checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL c37_valid: got %b expected 1", valid_o); end
      tick();
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL c37_valid_off: got %b expected 0", valid_o); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL c37_busy_off: got %b expected 0", busy_o); end
      repeat (4) tick();
      checks++; if (valid_cnt - c0 != 1) begin errors++; $display("FAIL c37_pulses: got %0d expected 1", valid_cnt - c0); end
   endtask

   task automatic test_clamp();
      int c0;
      int bad;
      apply_score(7'd99);
      checks++; if ({tens_seg_o, ones_seg_o} !== {7'h6F, 7'h6F}) begin errors++; $display("FAIL s99_segs: got %h/%h expected 6f/6f", tens_seg_o, ones_seg_o); end
      c0 = valid_cnt;
      apply_score(7'd115);
      checks++; if ({tens_seg_o, ones_seg_o} !== {7'h6F, 7'h6F}) begin errors++; $display("FAIL s115_segs: got %h/%h expected 6f/6f", tens_seg_o, ones_seg_o); end
      bad = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (busy_o !== 1'b0) bad++;
      end
      checks++; if (valid_cnt - c0 != 1) begin errors++; $display("FAIL s115_pulses: got %0d expected 1", valid_cnt - c0); end
      checks++; if (bad != 0) begin errors++; $display("FAIL s115_retrigger: got %0d busy cycles expected 0", bad); end
   endtask

   task automatic test_back_to_back();
      int c0;
      c0 = valid_cnt;
      score_i = 7'd5;
      repeat (3) tick();
      score_i = 7'd6;
      repeat (6) tick();
      checks++; if ({tens_seg_o, ones_seg_o} !== {7'h00, 7'h6D}) begin errors++; $display("FAIL b2b_first: got %h/%h expected 00/6d", tens_seg_o, ones_seg_o); end
      checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL b2b_valid1: got %b expected 1", valid_o); end
      tick();
      checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL b2b_redetect: got %b expected 1", busy_o); end
      repeat (7) tick();
      checks++; if (ones_seg_o !== 7'h6D) begin errors++; $display("FAIL b2b_hold: got %h expected 6d", ones_seg_o); end
      tick();
      checks++; if ({tens_seg_o, ones_seg_o} !== {7'h00, 7'h7D}) begin errors++; $display("FAIL b2b_second: got %h/%h expected 00/7d", tens_seg_o, ones_seg_o); end
      checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL b2b_valid2: got %b expected 1", valid_o); end
      repeat (10) tick();
      checks++; if (valid_cnt - c0 != 2) begin errors++; $display("FAIL b2b_pulses: got %0d expected 2", valid_cnt - c0); end
   endtask

   task automatic test_high_score();
      apply_score(7'd42);
      game_over_i = 1'b1;
      repeat (3) tick();
      checks++; if ({hi_tens_o, hi_ones_o} !== 8'h42) begin errors++; $display("FAIL hi_42: got %h expected 42", {hi_tens_o, hi_ones_o}); end
      game_over_i = 1'b0;
      apply_score(7'd10);
      game_over_i = 1'b1;
      repeat (3) tick();
      checks++; if ({hi_tens_o, hi_ones_o} !== 8'h42) begin errors++; $display("FAIL hi_10: got %h expected 42", {hi_tens_o, hi_ones_o}); end
      game_over_i = 1'b0;
      apply_score(7'd57);
      game_over_i = 1'b1;
      repeat (3) tick();
      checks++; if ({hi_tens_o, hi_ones_o} !== 8'h57) begin errors++; $display("FAIL hi_57: got %h expected 57", {hi_tens_o, hi_ones_o}); end
      apply_score(7'd80);
      checks++; if ({hi_tens_o, hi_ones_o} !== 8'h57) begin errors++; $display("FAIL hi_level: got %h expected 57", {hi_tens_o, hi_ones_o}); end
      game_over_i = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_reset_mid_conv();
      int c0;
      apply_score(7'd0);
      c0 = valid_cnt;
      score_i = 7'd23;
      repeat (5) tick();
      nRst_i = 1'b0;
      #1;
      checks++; if ({tens_seg_o, ones_seg_o} !== {7'h00, 7'h3F}) begin errors++; $display("FAIL rst_mid_segs: got %h/%h expected 00/3f", tens_seg_o, ones_seg_o); end
      checks++; if ({busy_o, valid_o} !== 2'b00) begin errors++; $display("FAIL rst_mid_ctl: got %b expected 00", {busy_o, valid_o}); end
      checks++; if ({hi_tens_o, hi_ones_o} !== 8'h00) begin errors++; $display("FAIL rst_mid_hi: got %h expected 00", {hi_tens_o, hi_ones_o}); end
      repeat (2) tick();
      nRst_i = 1'b1;
      repeat (8) tick();
      checks++; if (valid_cnt != c0) begin errors++; $display("FAIL rst_mid_novalid: got %0d pulses expected 0", valid_cnt - c0); end
      tick();
      checks++; if ({tens_seg_o, ones_seg_o} !== {7'h5B, 7'h4F}) begin errors++; $display("FAIL rst_resume: got %h/%h expected 5b/4f", tens_seg_o, ones_seg_o); end
      checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL rst_resume_valid: got %b expected 1", valid_o); end
   endtask

   initial begin
      nRst_i = 1'b0;
      score_i = 7'd0;
      game_over_i = 1'b0;
      test_reset();
      test_convert_37();
      test_clamp();
      test_back_to_back();
      test_high_score();
      test_reset_mid_conv();
      repeat (3) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
